// File: rtl/vram_dma.sv
// ---------------------------------------------------------------------------
// vram_dma
//   Write-side VRAM master. Copies a source byte stream (or a constant fill
//   byte) into the Pattern Memory Background (PMB) or Nametable (NTBL) windows
//   of the GPU VRAM. Writes happen only while vblank is high, so the
//   background renderer never fetches a half-updated region.
//
// Ports
//   cpu_clk, rst      : sole clock (rising edge), async active-high reset
//   start             : one-cycle request, sampled only when idle
//   dst_addr, length  : first destination address and byte count
//   fill_mode         : 1 = repeat fill_value, 0 = consume src stream
//   fill_value        : constant byte for fill mode
//   src_valid/data    : source stream; src_ready (combinational) acks a byte
//   vblank            : vertical blanking window, gates every write
//   vram_address, data_out, write_enable, SELECT_pmb, SELECT_ntbl
//                     : registered VRAM write bus, held for a full cycle
//   busy, done, err   : status; done is a one-cycle pulse, err is sticky
// ---------------------------------------------------------------------------
module vram_dma #(
  parameter int unsigned       ADDR_W    = 12,
  parameter int unsigned       LEN_W     = 11,
  parameter logic [ADDR_W-1:0] PMB_BASE  = ADDR_W'(12'h200),
  parameter logic [ADDR_W-1:0] NTBL_BASE = ADDR_W'(12'h400)
) (
  input  logic              cpu_clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic              fill_mode,
  input  logic [7:0]        fill_value,
  input  logic              src_valid,
  input  logic [7:0]        src_data,
  output logic              src_ready,
  input  logic              vblank,
  output logic [ADDR_W-1:0] vram_address,
  output logic [7:0]        data_out,
  output logic              write_enable,
  output logic              SELECT_pmb,
  output logic              SELECT_ntbl,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned PMB_SIZE  = 512;
  localparam int unsigned NTBL_SIZE = 1024;

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_WAIT_VBLANK = 2'd1,
    S_XFER        = 2'd2,
    S_DONE        = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  // Latched transfer context
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  remaining;
  logic              fill_mode_q;
  logic [7:0]        fill_value_q;

  // Decoded per-cycle conditions
  logic accept_c;
  logic beat_c;
  logic last_beat_c;
  logic in_pmb_c;
  logic in_ntbl_c;

  // Next values of the registered bus / status outputs
  logic [ADDR_W-1:0] vram_address_nxt;
  logic [7:0]        data_out_nxt;
  logic              write_enable_nxt;
  logic              sel_pmb_nxt;
  logic              sel_ntbl_nxt;
  logic              busy_nxt;
  logic              done_nxt;
  logic              err_nxt;

  assign accept_c    = (state == S_IDLE) && start;
  assign beat_c      = (state == S_XFER) && vblank && (fill_mode_q || src_valid);
  assign last_beat_c = beat_c && (remaining == LEN_W'(1));
  assign src_ready   = (state == S_XFER) && vblank && !fill_mode_q;

  // Window decode: offset from base, wrapped at ADDR_W, compared unsigned.
  // Addresses below a base wrap to a large offset and fall outside.
  assign in_pmb_c  = ADDR_W'(cur_addr - PMB_BASE)  < ADDR_W'(PMB_SIZE);
  assign in_ntbl_c = ADDR_W'(cur_addr - NTBL_BASE) < ADDR_W'(NTBL_SIZE);

  // State register
  always_ff @(posedge cpu_clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (length == LEN_W'(0)) begin
            state_nxt = S_DONE;
          end else if (vblank) begin
            state_nxt = S_XFER;
          end else begin
            state_nxt = S_WAIT_VBLANK;
          end
        end
      end
      S_WAIT_VBLANK: begin
        if (vblank) begin
          state_nxt = S_XFER;
        end
      end
      S_XFER: begin
        // Losing vblank parks the transfer; context registers are untouched
        if (!vblank) begin
          state_nxt = S_WAIT_VBLANK;
        end else if (last_beat_c) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Output logic: next values for the registered bus and status flags
  always_comb begin
    vram_address_nxt = vram_address;
    data_out_nxt     = data_out;
    write_enable_nxt = 1'b0;
    sel_pmb_nxt      = 1'b0;
    sel_ntbl_nxt     = 1'b0;
    busy_nxt         = busy;
    done_nxt         = 1'b0;
    err_nxt          = err;
    case (state)
      S_IDLE: begin
        if (start) begin
          busy_nxt = 1'b1;
          err_nxt  = 1'b0;
        end
      end
      S_XFER: begin
        if (beat_c) begin
          vram_address_nxt = cur_addr;
          data_out_nxt     = fill_mode_q ? fill_value_q : src_data;
          // Out-of-window bytes are consumed and counted but never strobed
          if (in_pmb_c || in_ntbl_c) begin
            write_enable_nxt = 1'b1;
            sel_pmb_nxt      = in_pmb_c;
            sel_ntbl_nxt     = in_ntbl_c;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      S_DONE: begin
        busy_nxt = 1'b0;
        done_nxt = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Registered VRAM bus and status; stable from one rising edge to the next,
  // so VRAM's falling-edge sample always sees a settled write
  always_ff @(posedge cpu_clk or posedge rst) begin
    if (rst) begin
      vram_address <= '0;
      data_out     <= '0;
      write_enable <= 1'b0;
      SELECT_pmb   <= 1'b0;
      SELECT_ntbl  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      vram_address <= vram_address_nxt;
      data_out     <= data_out_nxt;
      write_enable <= write_enable_nxt;
      SELECT_pmb   <= sel_pmb_nxt;
      SELECT_ntbl  <= sel_ntbl_nxt;
      busy         <= busy_nxt;
      done         <= done_nxt;
      err          <= err_nxt;
    end
  end

  // Transfer context: latched on accepted start, advanced on every beat
  always_ff @(posedge cpu_clk or posedge rst) begin
    if (rst) begin
      cur_addr     <= '0;
      remaining    <= '0;
      fill_mode_q  <= 1'b0;
      fill_value_q <= '0;
    end else if (accept_c) begin
      cur_addr     <= dst_addr;
      remaining    <= length;
      fill_mode_q  <= fill_mode;
      fill_value_q <= fill_value;
    end else if (beat_c) begin
      cur_addr  <= cur_addr + ADDR_W'(1);
      remaining <= remaining - LEN_W'(1);
    end
  end

endmodule

// File: tb/tb_vram_dma.sv
// ---------------------------------------------------------------------------
// tb_vram_dma
//   Scoreboard bench for vram_dma: expected VRAM writes are queued when
//   stimulus is driven and popped as the DUT strobes write_enable.
// ---------------------------------------------------------------------------
module tb_vram_dma;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned LEN_W  = 11;

  logic              cpu_clk;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] dst_addr;
  logic [LEN_W-1:0]  length;
  logic              fill_mode;
  logic [7:0]        fill_value;
  logic              src_valid;
  logic [7:0]        src_data;
  logic              src_ready;
  logic              vblank;
  logic [ADDR_W-1:0] vram_address;
  logic [7:0]        data_out;
  logic              write_enable;
  logic              SELECT_pmb;
  logic              SELECT_ntbl;
  logic              busy;
  logic              done;
  logic              err;

  vram_dma dut (
    .cpu_clk      (cpu_clk),
    .rst          (rst),
    .start        (start),
    .dst_addr     (dst_addr),
    .length       (length),
    .fill_mode    (fill_mode),
    .fill_value   (fill_value),
    .src_valid    (src_valid),
    .src_data     (src_data),
    .src_ready    (src_ready),
    .vblank       (vblank),
    .vram_address (vram_address),
    .data_out     (data_out),
    .write_enable (write_enable),
    .SELECT_pmb   (SELECT_pmb),
    .SELECT_ntbl  (SELECT_ntbl),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  typedef struct packed {
    logic [11:0] addr;
    logic [7:0]  data;
    logic        pmb;
    logic        ntbl;
  } wr_t;

  wr_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int wr_cnt   = 0;
  int done_cnt = 0;
  int last_we_cyc = 0;
  int done_cyc    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference window map: PMB 0x200-0x3FF, NTBL 0x400-0x7FF
  function automatic logic [1:0] win(input logic [11:0] a);
    logic p, n;
    p = (a >= 12'h200) && (a < 12'h400);
    n = (a >= 12'h400) && (a < 12'h800);
    return {p, n};
  endfunction

  task automatic push_exp(input logic [11:0] a, input logic [7:0] d);
    wr_t e;
    logic [1:0] w;
    w = win(a);
    if (w != 2'b00) begin
      e.addr = a; e.data = d; e.pmb = w[1]; e.ntbl = w[0];
      sb.push_back(e);
    end
  endtask

  // Monitor: sample the write bus at the falling edge, as VRAM does
  always @(negedge cpu_clk) begin
    wr_t e;
    cyc++;
    if (!rst) begin
      if (write_enable) begin
        wr_cnt++;
        last_we_cyc = cyc;
        if (sb.size() == 0) begin
          check("unexpected_write", 32'(vram_address), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("wr_addr", 32'(vram_address), 32'(e.addr));
          check("wr_data", 32'(data_out), 32'(e.data));
          check("wr_sel_pmb", 32'(SELECT_pmb), 32'(e.pmb));
          check("wr_sel_ntbl", 32'(SELECT_ntbl), 32'(e.ntbl));
        end
      end else begin
        check("sel_without_we", 32'({SELECT_pmb, SELECT_ntbl}), 32'd0);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic do_start(input logic [11:0] a, input logic [10:0] len,
                          input logic fm, input logic [7:0] fv);
    dst_addr = a; length = len; fill_mode = fm; fill_value = fv;
    start = 1'b1;
    @(posedge cpu_clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    src_valid = 1'b1;
    src_data  = b;
    do begin
      @(negedge cpu_clk);
      n++;
    end while (!src_ready && n < 200);
    check("src_ready_seen", 32'(src_ready), 32'd1);
    @(posedge cpu_clk); #1;
    src_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (done !== 1'b1 && n < max_cyc) begin
      @(negedge cpu_clk);
      n++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    @(negedge cpu_clk);
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int wb, db;
    rst = 1'b1; start = 1'b0; dst_addr = '0; length = '0; fill_mode = 1'b0;
    fill_value = '0; src_valid = 1'b0; src_data = '0; vblank = 1'b0;
    #3;
    check("rst_we", 32'(write_enable), 32'd0);
    check("rst_addr", 32'(vram_address), 32'd0);
    check("rst_status", 32'({busy, done, err, src_ready, SELECT_pmb, SELECT_ntbl}), 32'd0);
    repeat (3) @(posedge cpu_clk);
    #1 rst = 1'b0;
    vblank = 1'b1;

    // Fill of one colour byte in NTBL
    wb = wr_cnt;
    push_exp(12'h7C0, 8'h2A);
    do_start(12'h7C0, 11'd1, 1'b1, 8'h2A);
    wait_done("fill1", 50);
    check("fill1_writes", 32'(wr_cnt - wb), 32'd1);
    check("fill1_done_after_write", 32'(done_cyc - last_we_cyc), 32'd1);
    check("fill1_err", 32'(err), 32'd0);

    // Stream into PMB with a two-cycle source gap
    wb = wr_cnt;
    push_exp(12'h200, 8'h11); push_exp(12'h201, 8'h22);
    push_exp(12'h202, 8'h33); push_exp(12'h203, 8'h44);
    do_start(12'h200, 11'd4, 1'b0, 8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (2) @(posedge cpu_clk);
    #1;
    send_byte(8'h33);
    send_byte(8'h44);
    wait_done("stream", 50);
    check("stream_writes", 32'(wr_cnt - wb), 32'd4);

    // Fill of 10 bytes at NTBL base, vblank dropped after 3 beats
    wb = wr_cnt;
    for (int i = 0; i < 10; i++) push_exp(12'h400 + 12'(i), 8'h5C);
    do_start(12'h400, 11'd10, 1'b1, 8'h5C);
    repeat (3) @(posedge cpu_clk);
    #1 vblank = 1'b0;
    repeat (5) begin
      @(negedge cpu_clk);
      check("pause_busy", 32'(busy), 32'd1);
      @(posedge cpu_clk); #1;
    end
    check("pause_writes", 32'(wr_cnt - wb), 32'd3);
    vblank = 1'b1;
    wait_done("pause", 50);
    check("pause_total_writes", 32'(wr_cnt - wb), 32'd10);

    // PMB -> NTBL crossing
    wb = wr_cnt;
    push_exp(12'h3FE, 8'hA1); push_exp(12'h3FF, 8'hA2);
    push_exp(12'h400, 8'hA3); push_exp(12'h401, 8'hA4);
    do_start(12'h3FE, 11'd4, 1'b0, 8'h00);
    send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3); send_byte(8'hA4);
    wait_done("cross", 50);
    check("cross_writes", 32'(wr_cnt - wb), 32'd4);
    check("cross_err", 32'(err), 32'd0);

    // First byte below PMB: consumed, not written, err set
    wb = wr_cnt;
    push_exp(12'h1FF, 8'hB1);
    push_exp(12'h200, 8'hB2);
    do_start(12'h1FF, 11'd2, 1'b0, 8'h00);
    send_byte(8'hB1); send_byte(8'hB2);
    wait_done("oow", 50);
    check("oow_writes", 32'(wr_cnt - wb), 32'd1);
    check("oow_err", 32'(err), 32'd1);

    // Zero length: done on the second cycle after start, err cleared
    wb = wr_cnt;
    do_start(12'h300, 11'd0, 1'b1, 8'hEE);
    @(negedge cpu_clk);
    check("zero_done_early", 32'(done), 32'd0);
    check("zero_busy", 32'(busy), 32'd1);
    check("zero_err_cleared", 32'(err), 32'd0);
    @(negedge cpu_clk);
    check("zero_done", 32'(done), 32'd1);
    #1;
    check("zero_writes", 32'(wr_cnt - wb), 32'd0);

    // Start while busy is ignored
    @(posedge cpu_clk); #1;
    wb = wr_cnt; db = done_cnt;
    for (int i = 0; i < 6; i++) push_exp(12'h500 + 12'(i), 8'h77);
    do_start(12'h500, 11'd6, 1'b1, 8'h77);
    @(posedge cpu_clk); #1;
    do_start(12'h250, 11'd3, 1'b1, 8'h11);
    wait_done("busy_start", 50);
    repeat (5) @(negedge cpu_clk);
    #1;
    check("busy_start_writes", 32'(wr_cnt - wb), 32'd6);
    check("busy_start_dones", 32'(done_cnt - db), 32'd1);
    check("busy_start_idle", 32'(busy), 32'd0);

    // Async reset mid-stream
    @(posedge cpu_clk); #1;
    push_exp(12'h210, 8'hC1); push_exp(12'h211, 8'hC2); push_exp(12'h212, 8'hC3);
    do_start(12'h210, 11'd8, 1'b0, 8'h00);
    send_byte(8'hC1); send_byte(8'hC2); send_byte(8'hC3);
    #1 rst = 1'b1;
    #1;
    check("arst_we", 32'(write_enable), 32'd0);
    check("arst_addr_data", 32'({vram_address, data_out}), 32'd0);
    check("arst_status", 32'({busy, done, err, src_ready, SELECT_pmb, SELECT_ntbl}), 32'd0);
    check("arst_pending", 32'(sb.size()), 32'd1);
    sb.delete();
    repeat (2) @(posedge cpu_clk);
    #1 rst = 1'b0;
    wb = wr_cnt; db = done_cnt;
    src_valid = 1'b1; src_data = 8'h99;
    repeat (10) @(negedge cpu_clk);
    check("post_rst_src_ready", 32'(src_ready), 32'd0);
    #1;
    check("post_rst_writes", 32'(wr_cnt - wb), 32'd0);
    check("post_rst_dones", 32'(done_cnt - db), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    src_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vram_dma.md
Name: vram_dma

Overview:
- Write-side master for the GPU VRAM interface: copies a byte stream, or a constant fill value, into Pattern Memory Background (PMB) or the Nametable (NTBL).
- Drives the same vram_address / data / write_enable / SELECT_pmb / SELECT_ntbl bus that the background renderer's VRAM port consumes.
- Writes only while vblank is high, so on-screen fetches never see partial updates.
- Sits between the CPU-side control registers and the background and foreground VRAM arrays.

Parameters:
- ADDR_W, mapache64::VramAddrWidth, width of the VRAM address bus.
- LEN_W, 11, width of the transfer length; maximum transfer is 2047 bytes.
- PMB_BASE, 12'h200, first PMB address; the PMB window is 512 bytes.
- NTBL_BASE, 12'h400, first NTBL address; the NTBL window is 1024 bytes.

Ports:
- cpu_clk  in  1  sole clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- dst_addr  in  ADDR_W  first VRAM destination address; latched on start.
- length  in  LEN_W  byte count; latched on start.
- fill_mode  in  1  1 = write fill_value repeatedly; 0 = consume the src stream. Latched on start.
- fill_value  in  8  constant for fill mode; latched on start.
- src_valid  in  1  source byte available.
- src_data  in  8  source byte.
- src_ready  out  1  byte accepted this cycle when high together with src_valid.
- vblank  in  1  high during the vertical blanking interval.
- vram_address  out  ADDR_W  VRAM write address.
- data_out  out  8  VRAM write data; drives the VRAM data_in.
- write_enable  out  1  VRAM write strobe.
- SELECT_pmb  out  1  the current write targets PMB.
- SELECT_ntbl  out  1  the current write targets NTBL.
- busy  out  1  high from start acceptance until the done pulse.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky flag: at least one byte fell outside both windows; cleared on the next accepted start.

Behaviour:
- Reset (async, immediate): state = IDLE. All outputs 0, including vram_address, data_out, write_enable, both selects, busy, done, err and src_ready. Reset mid-transfer aborts the transfer with no further writes and no done pulse.
- State IDLE:
  - start=1 latches dst_addr, length, fill_mode and fill_value into cur_addr, remaining and the mode registers; sets busy=1 and clears err.
  - If length==0: go to DONE.
  - Else if vblank=1: go to XFER. Otherwise go to WAIT_VBLANK.
- State WAIT_VBLANK: go to XFER on the first cycle with vblank=1.
- State XFER:
  - Beat condition: vblank && (fill_mode || src_valid).
  - src_ready is combinational: (state==XFER) && vblank && !fill_mode.
  - On a beat, the registered outputs update on that edge: vram_address=cur_addr, data_out = fill_mode ? fill_value : src_data, write_enable=1.
  - Select decode: SELECT_pmb = (cur_addr - PMB_BASE) < 512; SELECT_ntbl = (cur_addr - NTBL_BASE) < 1024.
  - If cur_addr is in neither window: write_enable=0, both selects 0, err=1. The byte is still consumed and counted.
  - After each beat, cur_addr increments and wraps at 2^ADDR_W, and remaining decrements.
  - Without a beat, write_enable=0 and the selects go to 0.
  - vblank=0 in XFER: no beat that cycle; go to WAIT_VBLANK. The remaining count is preserved and the transfer resumes at the same address.
  - The beat that brings remaining to 0 goes to DONE.
- State DONE: done=1 and busy=0 for exactly one cycle; write_enable=0; then go to IDLE.
- Latency and bus timing:
  - A write appears on the bus one cycle after its beat.
  - The write is held at least until the following cpu_clk falling edge, where VRAM samples it.
  - Peak throughput is one byte per cycle.
- start while busy is ignored; the latched parameters are unchanged.
- A transfer that crosses from PMB into NTBL writes both regions correctly. The selects switch exactly at NTBL_BASE.
- Width rules: address subtraction is done at ADDR_W bits and compared unsigned; remaining is LEN_W bits.

Test Plan:
- Fill: vblank=1, dst=0x7C0, length=1, fill_mode=1, fill_value=0x2A → exactly one write, addr 0x7C0 (NTBL offset 0x3C0 = colour byte), data 0x2A, SELECT_ntbl=1; done pulses on the cycle after the write.
- Stream: vblank=1, dst=0x200, length=4, src bytes 11,22,33,44 with src_valid deasserted for 2 cycles after byte 2 → writes to 0x200–0x203 with those data; no write strobe during the gap; SELECT_pmb=1 throughout.
- Vblank pause: fill of 10 bytes at 0x400 with vblank dropped after 3 writes for 5 cycles → no writes while vblank=0; resumes at 0x403; 10 writes total; busy stays high until done.
- Boundary and error: dst=0x3FE, length=4, stream → 0x3FE/0x3FF carry SELECT_pmb, 0x400/0x401 carry SELECT_ntbl; a second run with dst=0x1FF, length=2 → first byte gives no write_enable and err=1, second byte is written to 0x200.
- Zero length and start while busy: length=0 → done on the second cycle after start with no write. start re-asserted mid-transfer → ignored, with the original dst/length completing.
- Async reset mid-stream: assert rst with no clock edge → all outputs 0 immediately; after release, no writes and no done until a new start.
